// File: rtl/ring_router_mux.sv
// ring_router_mux: merges ring pass-through and local injection flit streams
// onto one egress ring link. Wormhole arbitration with a round-robin pointer
// between packets, and a registered output stage with full throughput.

package ring_router_mux_pkg;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              first;
    logic              last;
  } flit_t;
endpackage

module ring_router_mux
  import ring_router_mux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  // ring pass-through sink
  input  flit_t i_ring_flit,
  input  logic  i_ring_valid,
  output logic  o_ring_ready_c,
  // local injection sink
  input  flit_t i_local_flit,
  input  logic  i_local_valid,
  output logic  o_local_ready_c,
  // merged egress source
  output flit_t o_mux_flit,
  output logic  o_mux_valid,
  input  logic  i_mux_ready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WORM = 1'b1;

  logic [0:0] r_state;
  logic       r_sel;        // 0 = ring owns output, 1 = local
  logic       r_prio_local; // round-robin pointer, 1 = local wins a tie
  logic       r_out_valid;
  flit_t      r_out_flit;

  logic [0:0] w_state_nxt;
  logic       w_sel_nxt;
  logic       w_prio_nxt;
  logic       w_out_valid_nxt;
  flit_t      w_out_flit_nxt;

  logic       w_space;
  logic       w_gnt_ring;
  logic       w_gnt_local;
  logic       w_xfer_ring;
  logic       w_xfer_local;
  logic       w_xfer;
  flit_t      w_flit;

  // State and output register update, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sel        <= 1'b0;
      r_prio_local <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_flit   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_prio_local <= w_prio_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_flit   <= w_out_flit_nxt;
    end
  end

  // Grant, input handshakes and next-state / output-register load
  always_comb begin
    w_gnt_ring      = 1'b0;
    w_gnt_local     = 1'b0;
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_prio_nxt      = r_prio_local;
    w_out_valid_nxt = r_out_valid;
    w_out_flit_nxt  = r_out_flit;

    w_space = !r_out_valid || i_mux_ready;

    case (r_state)
      ST_IDLE: begin
        if (i_ring_valid && i_local_valid) begin
          w_gnt_local = r_prio_local;
          w_gnt_ring  = !r_prio_local;
        end else begin
          w_gnt_ring  = i_ring_valid;
          w_gnt_local = i_local_valid;
        end
      end
      ST_WORM: begin
        // the packet owner keeps the link; the other source is locked out
        w_gnt_local = r_sel;
        w_gnt_ring  = !r_sel;
      end
      default: begin
        w_gnt_ring  = 1'b0;
        w_gnt_local = 1'b0;
      end
    endcase

    // readies are held low while reset is asserted
    o_ring_ready_c  = w_gnt_ring  && w_space && rst_n;
    o_local_ready_c = w_gnt_local && w_space && rst_n;

    w_xfer_ring  = i_ring_valid  && o_ring_ready_c;
    w_xfer_local = i_local_valid && o_local_ready_c;
    w_xfer       = w_xfer_ring || w_xfer_local;
    w_flit       = w_xfer_local ? i_local_flit : i_ring_flit;

    if (w_xfer) begin
      w_out_flit_nxt  = w_flit;
      w_out_valid_nxt = 1'b1;
      if (r_state == ST_IDLE) begin
        // any flit accepted while idle starts a packet and moves the pointer
        w_prio_nxt = w_xfer_ring;
        if (!w_flit.last) begin
          w_state_nxt = ST_WORM;
          w_sel_nxt   = w_xfer_local;
        end
      end else if (w_flit.last) begin
        w_state_nxt = ST_IDLE;
      end
    end else if (i_mux_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  assign o_mux_valid = r_out_valid;
  assign o_mux_flit  = r_out_flit;

endmodule

// File: doc/ring_router_mux.md
# ring_router_mux

Merges two debug-interconnect flit streams, ring pass-through traffic and locally injected traffic, onto one outgoing ring link. It is the egress counterpart of `ring_router_demux` inside a ring router. Arbitration is per packet (wormhole): once a packet wins, it holds the output until its `last` flit transfers. Packets are arbitrated round-robin between the two sources. The output is registered, giving one cycle of latency and full throughput.

## Interface
Parameters:
- none. Flit format and width come from `dii_channel`: `data`, `first`, `last`, `valid`, `ready`.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low; sampled on the `clk` rising edge.
- `in_ring`  dii_channel (sink)  —  flits arriving from the upstream ring hop.
- `in_local`  dii_channel (sink)  —  flits injected by the local module.
- `out_mux`  dii_channel (source)  —  merged flits to the downstream ring hop.

## Operation
Handshake:
- A flit transfers on any channel in a cycle where `valid & ready` at the `clk` edge.
- A source holds `data/first/last` stable while `valid` is high and `ready` is low.

State:
- `worm` (1b): a packet currently owns the output.
- `sel` (1b): owner of the output; 0 = ring, 1 = local.
- `prio_local` (1b): round-robin pointer.
- Output register: `out_valid`, `out_data`, `out_first`, `out_last`.

Output register:
- `space = !out_valid | out_mux.ready`.
- On an input transfer: load the granted flit into the output register and set `out_valid=1`.
- Else, if `out_mux.ready`: set `out_valid=0`.
- `out_mux.valid/data/first/last` are driven directly from the register.

Arbitration (combinational grant):
- IDLE (`worm=0`):
  - Only one input valid: grant that input.
  - Both valid: grant local if `prio_local`, else ring.
  - Neither valid: no grant.
- WORM (`worm=1`): grant `sel` only. The other input's `ready` is 0 regardless of its `valid`.
- `in_X.ready = grant_X & space`. At most one input is ready in any cycle.

Transitions (on a granted transfer):
- IDLE, flit not `last`: `worm<=1`, `sel<=granted`, `prio_local<=(granted==ring)`.
- IDLE, flit has `last` (single-flit packet): stay IDLE, `prio_local<=(granted==ring)`.
- WORM, flit has `last`: `worm<=0`. `sel` and `prio_local` are unchanged.
- WORM, flit not `last`: no state change.

Other rules:
- The `first` bit is forwarded but not checked. Any flit accepted in IDLE starts a packet, even with `first=0`.
- The `data` word is forwarded unmodified. No routing decision is made here.
- Reset mid-packet: the worm is abandoned and the output register is flushed (`out_valid=0`). Upstream flits of the cut packet that arrive after reset are treated as new packets.

## Timing
- Reset values:
  - `out_mux.valid=0`, `out_data=0`, `out_first=0`, `out_last=0`.
  - `worm=0`, `sel=0`, `prio_local=0` (ring has priority first).
  - `in_ring.ready=0`, `in_local.ready=0` during the reset cycle.
- Latency: a flit accepted at edge N is visible on `out_mux` after edge N and until it is consumed.
- Throughput: with `out_mux.ready` held at 1, one flit per cycle is sustained, with no bubble between packets or between sources.
- Backpressure: `out_mux.ready=0` with `out_valid=1` makes `space=0`. Both input readies drop in the same cycle, and the register holds its contents.
- Simultaneous events:
  - Packet end and new packet: the `last` flit of a packet and the first flit of the next packet (from either source) transfer on consecutive cycles. The next grant decision uses the updated `prio_local`.
  - Output drain and input load: in the same cycle the new flit replaces the old one, and `out_valid` stays 1.
- There is no combinational path from `in_*.valid` to `out_mux.*`. Input `ready` depends combinationally on `out_mux.ready`, the input `valid`s and state.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles while both inputs are valid. Required: no ready, `out_mux.valid=0`. After release, the first grant goes to ring (`prio_local=0`).
- Contention: both inputs present continuously, 3-flit packets, ring data 0x0101.., local data 0x0202.., `out_mux.ready=1`. Required: output order ring pkt, local pkt, ring pkt, …, with each packet's 3 flits contiguous, no interleaving and no idle cycles.
- Single-flit packets: both inputs carry `first=last=1` flits. Required: output alternates ring, local, ring, … every cycle.
- Backpressure mid-packet: local 4-flit packet; `out_mux.ready=0` for 3 cycles after flit 2. Required: output holds flit 2. `in_ring.ready` stays 0 for the whole packet even though ring is valid. Flits 3–4 follow when ready returns, then ring is granted.
- Reset mid-worm: assert `rst_n=0` after flit 2 of a 5-flit ring packet. Required: `out_mux.valid=0` next cycle. After release, both sources are eligible and a local packet can win.
- Random: random `valid` and `ready` on all channels, 10k cycles, scoreboard per source. Required: every packet is delivered intact and in order, `ready` is never high on both inputs, and no source waits more than one competing packet.
